// File: rtl/quad_steer_multi.sv
// Multi-channel joystick-to-quadrature steering encoder: left/right requests become
// Gray-code A/B steering phases with a runtime step period and hold-to-accelerate.
module quad_steer_multi #(
   parameter int unsigned CHANNELS        = 2,
   parameter int unsigned DIV_W           = 16,
   parameter int unsigned ACCEL_STEPS     = 4,
   parameter int unsigned STEPS_PER_LEVEL = 8,
   localparam int unsigned LW = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [DIV_W-1:0]       clkdiv,
   input  logic                   accel_en,
   input  logic [CHANNELS-1:0]    left,
   input  logic [CHANNELS-1:0]    right,
   output logic [2*CHANNELS-1:0]  steer,
   output logic [CHANNELS-1:0]    moving,
   output logic [LW*CHANNELS-1:0] accel_level
);

   localparam int unsigned RW = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL + 1) : 1;
   localparam logic [LW-1:0] LevelMax = LW'(ACCEL_STEPS - 1);
   localparam logic [RW-1:0] RunLast  = RW'(STEPS_PER_LEVEL - 1);

   typedef enum logic [1:0] {StIdle, StRight, StLeft} state_e;

   // clkdiv of 0 behaves as 1; shared by all channels before the per-channel shift
   logic [DIV_W-1:0] base_period;
   assign base_period = (clkdiv == '0) ? DIV_W'(1) : clkdiv;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic             l_q, r_q;
      state_e           state_q, state_d;
      logic [1:0]       phase_q, phase_d, phase_r, phase_l;
      logic [DIV_W-1:0] cnt_q, cnt_d, period;
      logic [LW-1:0]    level_q, level_d;
      logic [RW-1:0]    run_q, run_d;

      always_comb begin
         state_d = StIdle;
         if (r_q && !l_q) begin
            state_d = StRight;
         end else if (l_q && !r_q) begin
            state_d = StLeft;
         end
      end

      always_comb begin
         period = base_period >> level_q;
         if (period == '0) begin
            period = DIV_W'(1);
         end
      end

      // Gray successors: right 00->01->11->10, left is the reverse walk
      always_comb begin
         phase_r = 2'b00;
         phase_l = 2'b00;
         case (phase_q)
            2'b00: begin phase_r = 2'b01; phase_l = 2'b10; end
            2'b01: begin phase_r = 2'b11; phase_l = 2'b00; end
            2'b11: begin phase_r = 2'b10; phase_l = 2'b01; end
            default: begin phase_r = 2'b00; phase_l = 2'b11; end
         endcase
      end

      // Idle, fresh entry and direct reversal all clear the counters without stepping
      always_comb begin
         cnt_d   = '0;
         level_d = '0;
         run_d   = '0;
         phase_d = phase_q;
         if (state_d != StIdle && state_d == state_q) begin
            cnt_d   = cnt_q + DIV_W'(1);
            level_d = level_q;
            run_d   = run_q;
            if (cnt_q >= period - DIV_W'(1)) begin
               cnt_d   = '0;
               phase_d = (state_q == StRight) ? phase_r : phase_l;
               if (run_q == RunLast) begin
                  run_d = '0;
                  if (level_q != LevelMax) begin
                     level_d = level_q + LW'(1);
                  end
               end else begin
                  run_d = run_q + RW'(1);
               end
            end
            if (!accel_en) begin
               level_d = '0;
               run_d   = '0;
            end
         end
      end

      always_ff @(posedge CLK) begin
         if (RESET) begin
            l_q     <= 1'b0;
            r_q     <= 1'b0;
            state_q <= StIdle;
            phase_q <= 2'b00;
            cnt_q   <= '0;
            level_q <= '0;
            run_q   <= '0;
         end else begin
            l_q     <= left[ch];
            r_q     <= right[ch];
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            run_q   <= run_d;
         end
      end

      assign steer[2*ch +: 2]        = phase_q;
      assign moving[ch]              = (state_q != StIdle);
      assign accel_level[LW*ch +: LW] = level_q;
   end

endmodule
